regfile_wb_arbiter: RTL and testbench

- Shares the single register-file write port (write address, write data, write enable) among NREQ writeback requesters, e.g. ALU, load unit and debug port.
- Grants at most one write per cycle using round-robin priority, with registered outputs and a one-cycle ack handshake.
- Sits between the writeback sources and the register file.
- Counts contention cycles for performance debug.

---
 rtl/regfile_wb_arbiter_if.sv | 25 ++
 rtl/regfile_wb_arbiter.sv | 105 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the requesters and the register-file write-port arbiter.
// The slave side is the arbiter. The master side is the set of writeback sources plus the register file.
interface regfile_wb_arbiter_if #(
    parameter int NREQ = 3,
    parameter int CW   = 16
);
    logic [NREQ-1:0]      req;
    logic [5*NREQ-1:0]    req_addr;
    logic [32*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      ack;
    logic [4:0]           reg_W_addr;
    logic [31:0]          wdata;
    logic                 reg_we;
    logic [CW-1:0]        contention_cnt;

    modport slave (
        input  req, req_addr, req_data,
        output ack, reg_W_addr, wdata, reg_we, contention_cnt
    );

    modport master (
        output req, req_addr, req_data,
        input  ack, reg_W_addr, wdata, reg_we, contention_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// It grants one writeback per cycle, and every output is registered.
// The ack is a one-cycle pulse. A requester that is acked in the current cycle is masked out of arbitration.
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int CW   = 16
) (
    input  logic                  clk,
    input  logic                  rst,   // asynchronous, active low
    regfile_wb_arbiter_if.slave   bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IW = PW + 1;

    logic [NREQ-1:0] ack_q, ack_d;
    logic [4:0]      addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            we_q, we_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;

    logic [NREQ-1:0] eligible;
    logic [4:0]      addr_arr [NREQ];
    logic [31:0]     data_arr [NREQ];
    logic            grant_valid;
    logic [PW-1:0]   win;
    logic            multi_eligible;

    // Unpack the flat request buses.
    // A requester whose ack is showing this cycle cannot win again while it retires its item.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign eligible[gi] = bus.req[gi] & ~ack_q[gi];
            assign addr_arr[gi] = bus.req_addr[5*gi +: 5];
            assign data_arr[gi] = bus.req_data[32*gi +: 32];
        end
    endgenerate

    // Two or more bits are set exactly when clearing the lowest set bit leaves something behind.
    assign multi_eligible = |(eligible & (eligible - {{(NREQ-1){1'b0}}, 1'b1}));

    // Find the first eligible index, scanning from ptr and wrapping around.
    // The scan runs from the far end so that the nearest candidate is written last and wins.
    always_comb begin
        logic [IW-1:0] idx;
        grant_valid = 1'b0;
        win         = '0;
        idx         = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = {1'b0, ptr_q} + IW'(k);
            if (idx >= IW'(NREQ)) begin
                idx = idx - IW'(NREQ);
            end
            if (eligible[idx[PW-1:0]]) begin
                grant_valid = 1'b1;
                win         = idx[PW-1:0];
            end
        end
    end

    // Next-state values for the registered outputs, the pointer and the saturating counter.
    always_comb begin
        ack_d   = '0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (grant_valid) begin
            ack_d[win] = 1'b1;
            addr_d     = addr_arr[win];
            wdata_d    = data_arr[win];
            we_d       = (addr_arr[win] != 5'd0);   // writes to register 0 are acked but have no effect
            ptr_d      = (win == PW'(NREQ - 1)) ? '0 : win + PW'(1);
        end
        if (multi_eligible && (cnt_q != '1)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State registers. The asynchronous reset drops any grant that is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            ack_q   <= ack_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.ack            = ack_q;
    assign bus.reg_W_addr     = addr_q;
    assign bus.wdata          = wdata_q;
    assign bus.reg_we         = we_q;
    assign bus.contention_cnt = cnt_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter.
// A behavioural model predicts each cycle's outputs from the requests it sees.
// Directed phases pin that model with literal values, and a randomized phase follows.
module tb_regfile_wb_arbiter;
    localparam int N  = 3;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NREQ(N), .CW(CW)) bus ();

    regfile_wb_arbiter #(.NREQ(N), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Requester-side stimulus state
    logic        t_req  [N];
    logic [4:0]  t_addr [N];
    logic [31:0] t_data [N];
    int          p_new = 0;
    int          p_wd  = 0;
    bit          nz_addr = 1'b0;
    bit          auto_drive = 1'b0;

    // Behavioural model state
    int          m_ptr;
    int          m_ack;       // index acked in the current cycle, or -1
    int          m_cnt;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic        m_we;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.req[i]               = t_req[i];
            bus.req_addr[5*i +: 5]   = t_addr[i];
            bus.req_data[32*i +: 32] = t_data[i];
        end
    endtask

    task automatic new_item(input int i);
        t_req[i]  = 1'b1;
        t_addr[i] = nz_addr ? 5'($urandom_range(1, 31)) : 5'($urandom_range(0, 31));
        t_data[i] = $urandom;
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_ack  = -1;
        m_cnt  = 0;
        m_addr = '0;
        m_data = '0;
        m_we   = 1'b0;
    endtask

    // Apply one clock edge's worth of the arbitration rules to the model.
    task automatic model_edge();
        bit e [N];
        int ne;
        int w;
        int idx;
        ne = 0;
        w  = -1;
        for (int i = 0; i < N; i++) begin
            e[i] = t_req[i] && (m_ack != i);
            if (e[i]) ne++;
        end
        if (ne >= 2 && m_cnt < (1 << CW) - 1) m_cnt++;
        for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (w < 0 && e[idx]) w = idx;
        end
        if (w >= 0) begin
            m_ack  = w;
            m_addr = t_addr[w];
            m_data = t_data[w];
            m_we   = (t_addr[w] != 0);
            m_ptr  = (w + 1) % N;
        end else begin
            m_ack = -1;
            m_we  = 1'b0;
        end
    endtask

    // Compare every DUT output against the model's prediction.
    task automatic compare();
        logic [31:0] exp_ack;
        exp_ack = (m_ack >= 0) ? (32'd1 << m_ack) : 32'd0;
        chk("ack",            32'(bus.ack),            exp_ack);
        chk("reg_we",         32'(bus.reg_we),         32'(m_we));
        chk("reg_W_addr",     32'(bus.reg_W_addr),     32'(m_addr));
        chk("wdata",          bus.wdata,               m_data);
        chk("contention_cnt", 32'(bus.contention_cnt), 32'(m_cnt));
        if (m_ack >= 0)
            $display("grant req=%0d addr=%0d data=%h we=%0d cnt=%0d", m_ack, m_addr, m_data, m_we, m_cnt);
    endtask

    // Requester behaviour: an item is retired in its ack cycle, then the requester offers another item or goes idle.
    task automatic drive_auto();
        for (int i = 0; i < N; i++) begin
            if (m_ack == i) begin
                if ($urandom_range(0, 99) < p_new) new_item(i);
                else t_req[i] = 1'b0;
            end else if (!t_req[i]) begin
                if ($urandom_range(0, 99) < p_new) new_item(i);
            end else if ($urandom_range(0, 99) < p_wd) begin
                t_req[i] = 1'b0;
            end
        end
        apply();
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_edge();
        @(negedge clk);
        compare();
        if (auto_drive) drive_auto();
    endtask

    initial begin
        logic [31:0] saved0;
        for (int i = 0; i < N; i++) begin
            t_req[i]  = 1'b0;
            t_addr[i] = '0;
            t_data[i] = '0;
        end
        apply();
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        compare();
        chk("reset_ack", 32'(bus.ack), 32'd0);
        chk("reset_cnt", 32'(bus.contention_cnt), 32'd0);
        rst = 1'b1;

        // Idle after reset
        repeat (5) step();
        chk("idle_we", 32'(bus.reg_we), 32'd0);
        chk("idle_wdata", bus.wdata, 32'd0);

        // Single requester: one ack, and no second ack while req is still high during the ack cycle
        t_req[1] = 1'b1; t_addr[1] = 5'd5; t_data[1] = 32'hDEADBEEF; apply();
        step();
        chk("single_ack", 32'(bus.ack), 32'b010);
        chk("single_we", 32'(bus.reg_we), 32'd1);
        chk("single_addr", 32'(bus.reg_W_addr), 32'd5);
        chk("single_data", bus.wdata, 32'hDEADBEEF);
        step();
        chk("single_noreack", 32'(bus.ack), 32'd0);
        t_req[1] = 1'b0; apply();
        step();

        // Pointer is now 2, so requester 0 must win over requester 1 (wrap-around)
        t_req[0] = 1'b1; t_addr[0] = 5'd7; t_data[0] = 32'h00000A0A;
        t_req[1] = 1'b1; t_addr[1] = 5'd9; t_data[1] = 32'h0000B0B0; apply();
        step();
        chk("wrap_first", 32'(bus.ack), 32'b001);
        chk("wrap_first_data", bus.wdata, 32'h00000A0A);
        t_req[0] = 1'b0; apply();
        step();
        chk("wrap_second", 32'(bus.ack), 32'b010);
        chk("wrap_second_addr", 32'(bus.reg_W_addr), 32'd9);
        t_req[1] = 1'b0; apply();
        step();

        // Write to register 0: acked, no write enable
        t_req[2] = 1'b1; t_addr[2] = 5'd0; t_data[2] = 32'h12345678; apply();
        step();
        chk("r0_ack", 32'(bus.ack), 32'b100);
        chk("r0_we", 32'(bus.reg_we), 32'd0);
        chk("r0_data", bus.wdata, 32'h12345678);
        t_req[2] = 1'b0; apply();
        step();

        // All three requesting continuously: strict rotation, starting at 0 because the pointer advanced past 2
        p_new = 100; p_wd = 0; nz_addr = 1'b1;
        for (int i = 0; i < N; i++) new_item(i);
        apply();
        auto_drive = 1'b1;
        for (int g = 0; g < 6; g++) begin
            step();
            chk("rr_ack", 32'(bus.ack), 32'd1 << (g % N));
            chk("rr_we", 32'(bus.reg_we), 32'd1);
        end
        repeat ((1 << CW) + 10) step();
        chk("cnt_saturated", 32'(bus.contention_cnt), 32'hF);

        // Asynchronous reset mid-cycle with a grant pending; the requester keeps its item
        auto_drive = 1'b0;
        @(posedge clk);
        model_edge();
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        compare();
        chk("midreset_ack", 32'(bus.ack), 32'd0);
        chk("midreset_cnt", 32'(bus.contention_cnt), 32'd0);
        saved0 = t_data[0];
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("post_reset_ack", 32'(bus.ack), 32'b001);
        chk("post_reset_data", bus.wdata, saved0);

        // Randomized traffic, including register-0 writes and withdrawn requests
        p_new = 40; p_wd = 5; nz_addr = 1'b0;
        auto_drive = 1'b1;
        drive_auto();
        repeat (300) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
